mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
// Responder end of the pipeline's memory request interface. It accepts the
// instruction-fetch read port (iREN) and the MEM-stage data port (dREN/dWEN),
// arbitrates them onto one single-ported RAM, and returns one-cycle
// ihit/dhit pulses with load data. It sits between the datapath stages and
// the RAM model, and is the block that produces the dhit/ihit consumed by the
// MEM stage.
// PARAMETERS
// AW       32   address width (bits)
// DW       32   data width (bits)
// FAIR     4    max consecutive data grants while iREN is pending before a
//               forced instruction grant
// TIMEOUT  255  max wait cycles for ramready before the access is aborted
// PORTS
// CLK       in   1   clock, all state updates on posedge
// RST       in   1   synchronous, active-high reset
// iREN      in   1   instruction read request
// iaddr     in   AW  instruction address
// dREN      in   1   data read request
// dWEN      in   1   data write request
// daddr     in   AW  data address
// dstore    in   DW  data write value
// ihit      out  1   instruction access complete, 1-cycle pulse
// iload     out  DW  instruction read data, valid while ihit=1
// dhit      out  1   data access complete, 1-cycle pulse
// dload     out  DW  data read data, valid while dhit=1 after a read
// ramREN    out  1   RAM read strobe
// ramWEN    out  1   RAM write strobe
// ramaddr   out  AW  RAM address
// ramstore  out  DW  RAM write data
// ramload   in   DW  RAM read data, valid when ramready=1
// ramready  in   1   RAM access complete this cycle
// err       out  1   sticky: a timeout occurred
// BEHAVIOUR
// Reset (RST=1 at posedge):
// - state=IDLE; every output, fair_cnt and wait_cnt are 0.
// - Reset overrides any access in flight; RAM strobes drop at the same edge.
// FSM states: IDLE, DREQ, IREQ, RESP.
// IDLE:
// - (dREN|dWEN) and not forced -> DREQ; else iREN -> IREQ; else stay.
// - forced = iREN && fair_cnt==FAIR.
// - Address, store data and op are latched at the grant edge.
// DREQ / IREQ:
// - ramaddr and ramstore come from the latched values.
// - Data: ramREN=dREN, ramWEN=dWEN. Instruction: ramREN=1.
// - If dREN and dWEN are both high, the write wins (ramREN=0).
// - On ramready=1: capture ramload into dload (data read) or iload
//   (instruction), drop strobes, go to RESP.
// - A data write leaves dload unchanged.
// - wait_cnt increments each cycle ramready=0.
// - At wait_cnt==TIMEOUT: abort, load value=0, err<=1, go to RESP.
// RESP:
// - ihit or dhit = 1 for exactly this cycle; strobes=0.
// - Go to IDLE; new requests are not sampled in RESP.
// - Requesters must deassert the request at the edge ending the hit cycle.
// Latency and handshake:
// - Minimum latency is 3 cycles from request to hit: grant edge, ramready in
//   the first REQ cycle, hit in RESP.
// - Requests that drop mid-access do not abort it; the hit still pulses.
// Fairness (fair_cnt):
// - On a data grant with iREN=1: fair_cnt++, saturating at FAIR.
// - Reset to 0 on any instruction grant, or on a data grant with iREN=0.
// Widths and outputs:
// - wait_cnt is $clog2(TIMEOUT+1) bits and clears on every grant.
// - ihit and dhit are never high together.
// - err clears only on RST.
// TESTING
// 1. Reset, then iREN=1 iaddr=0x40, ramready=1 immediately, ramload=0x8C220004
//    -> ihit pulses at cycle 3, iload=0x8C220004.
// 2. dREN=1 and iREN=1 in the same cycle -> DREQ granted first; the
//    instruction is served right after RESP; ihit follows dhit.
// 3. dWEN=1 daddr=0x100 dstore=0xDEADBEEF, 2 wait cycles
//    -> ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF; dhit at cycle 5;
//    dload unchanged.
// 4. dREN held continuously, iREN=1, FAIR=4 -> after 4 data grants the 5th
//    grant is instruction; fair_cnt returns to 0.
// 5. ramready held 0 with TIMEOUT=255 -> dhit after 257 cycles, dload=0,
//    err=1 and stays 1 until RST.
// 6. Assert RST while in DREQ with ramREN=1 -> next cycle all outputs 0,
//    state IDLE, no hit pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Memory arbiter: serves the instruction-fetch port and the data port onto a
// single-ported RAM, with bounded starvation of instruction fetches and a
// ramready watchdog that aborts stuck accesses.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int FAIR    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          iREN,
    input  logic [AW-1:0] iaddr,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dstore,
    output logic          ihit,
    output logic [DW-1:0] iload,
    output logic          dhit,
    output logic [DW-1:0] dload,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [DW-1:0] ramstore,
    input  logic [DW-1:0] ramload,
    input  logic          ramready,
    output logic          err
);

    // state | meaning
    // IDLE  | no access; sample requests and grant one
    // DREQ  | data access on the RAM, waiting for ramready
    // IREQ  | instruction fetch on the RAM, waiting for ramready
    // RESP  | one-cycle hit pulse for the access just finished
    typedef enum logic [1:0] {IDLE, DREQ, IREQ, RESP} state_t;

    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int FW = (FAIR > 0) ? $clog2(FAIR + 1) : 1;
    localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);
    localparam logic [FW-1:0] FAIR_MAX = FW'(FAIR);

    state_t        state, next_state;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_store;
    logic          lat_ren, lat_wen, lat_instr;
    logic [FW-1:0] fair_cnt;
    logic [WW-1:0] wait_cnt;

    logic forced, grant_d, grant_i, in_req, timed_out;

    // Grant decision: data wins unless the instruction port has been starved
    always_comb begin
        forced    = iREN && (fair_cnt == FAIR_MAX);
        grant_d   = (state == IDLE) && (dREN || dWEN) && !forced;
        grant_i   = (state == IDLE) && iREN && !grant_d;
        in_req    = (state == DREQ) || (state == IREQ);
        timed_out = in_req && !ramready && (wait_cnt == WAIT_MAX);
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_d)      next_state = DREQ;
                else if (grant_i) next_state = IREQ;
            end
            DREQ, IREQ: begin
                if (ramready || timed_out) next_state = RESP;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from the state and the operation latched at grant
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ihit     = 1'b0;
        dhit     = 1'b0;
        case (state)
            DREQ: begin
                ramWEN   = lat_wen;
                ramREN   = lat_ren && !lat_wen;
                ramaddr  = lat_addr;
                ramstore = lat_store;
            end
            IREQ: begin
                ramREN  = 1'b1;
                ramaddr = lat_addr;
            end
            RESP: begin
                ihit = lat_instr;
                dhit = !lat_instr;
            end
            default: ;
        endcase
    end

    // Request latching, fairness and wait counters, load capture, sticky error
    always_ff @(posedge CLK) begin
        if (RST) begin
            lat_addr  <= '0;
            lat_store <= '0;
            lat_ren   <= 1'b0;
            lat_wen   <= 1'b0;
            lat_instr <= 1'b0;
            fair_cnt  <= '0;
            wait_cnt  <= '0;
            iload     <= '0;
            dload     <= '0;
            err       <= 1'b0;
        end else begin
            if (grant_d) begin
                lat_addr  <= daddr;
                lat_store <= dstore;
                lat_ren   <= dREN;
                lat_wen   <= dWEN;
                lat_instr <= 1'b0;
                wait_cnt  <= '0;
                if (!iREN)                    fair_cnt <= '0;
                else if (fair_cnt != FAIR_MAX) fair_cnt <= fair_cnt + 1'b1;
            end else if (grant_i) begin
                lat_addr  <= iaddr;
                lat_store <= '0;
                lat_ren   <= 1'b1;
                lat_wen   <= 1'b0;
                lat_instr <= 1'b1;
                wait_cnt  <= '0;
                fair_cnt  <= '0;
            end else if (in_req) begin
                if (ramready) begin
                    if (lat_instr)                 iload <= ramload;
                    else if (lat_ren && !lat_wen)  dload <= ramload;
                end else if (timed_out) begin
                    if (lat_instr)                 iload <= '0;
                    else if (lat_ren && !lat_wen)  dload <= '0;
                    err <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

endmodule
